// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant locked for a whole cyc,
// with a per-transfer watchdog that turns a silent slave into a bus error.
module wb_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rstn_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_W-1:0]     m0_adr_i,
    input  logic [DATA_W-1:0]     m0_dat_i,
    input  logic [DATA_W/8-1:0]   m0_sel_i,
    output logic [DATA_W-1:0]     m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_W-1:0]     m1_adr_i,
    input  logic [DATA_W-1:0]     m1_dat_i,
    input  logic [DATA_W/8-1:0]   m1_sel_i,
    output logic [DATA_W-1:0]     m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    output logic [DATA_W/8-1:0]   s_sel_o,
    input  logic [DATA_W-1:0]     s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,

    output logic                  timeout_o,
    output logic [1:0]            grant_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic              g_cyc;
    logic              g_stb;
    logic              g_we;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;
    logic [SEL_W-1:0]  g_sel;
    logic              granted;
    logic              wd_fire;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Grant is only released when the owner drops cyc, so bursts and RMW stay whole.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        case (state_q)
            GNT0: begin
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i;
                g_we  = m0_we_i;
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
                g_sel = m0_sel_i;
            end
            GNT1: begin
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i;
                g_we  = m1_we_i;
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
                g_sel = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign granted = (state_q != IDLE);

    // A real ack or err in the firing cycle wins over the watchdog.
    assign wd_fire = WD_EN && granted && g_stb && !s_ack_i && !s_err_i
                     && (wd_cnt_q == WD_LAST);

    always_comb begin
        if (!WD_EN || !granted || (state_d != state_q) || !g_stb
            || s_ack_i || s_err_i || wd_fire) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    assign s_cyc_o   = g_cyc;
    assign s_stb_o   = g_stb & ~wd_fire;
    assign s_we_o    = g_we;
    assign s_adr_o   = g_adr;
    assign s_dat_o   = g_dat;
    assign s_sel_o   = g_sel;

    assign m0_dat_o  = (state_q == GNT0) ? s_dat_i : '0;
    assign m0_ack_o  = (state_q == GNT0) & s_ack_i;
    assign m0_err_o  = (state_q == GNT0) & (s_err_i | wd_fire);

    assign m1_dat_o  = (state_q == GNT1) ? s_dat_i : '0;
    assign m1_ack_o  = (state_q == GNT1) & s_ack_i;
    assign m1_err_o  = (state_q == GNT1) & (s_err_i | wd_fire);

    assign timeout_o = wd_fire;
    assign grant_o   = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: scenario tasks with a queue of expected transfers
// popped and compared whenever the slave acknowledges.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;
    logic          timeout_o;
    logic [1:0]    grant_o;

    wb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .timeout_o(timeout_o), .grant_o(grant_o)
    );

    typedef struct packed {
        logic [1:0]    ack;
        logic [1:0]    gnt;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
    } xact_t;

    xact_t exp_q[$];
    xact_t exp_x, obs_x;
    int    n_checks = 0;
    int    n_fail   = 0;

    wire [141:0] all_out = {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                            m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
                            timeout_o};

    function automatic xact_t mk(input logic [1:0] who, input logic [AW-1:0] adr,
                                 input logic we, input logic [DW-1:0] dat);
        xact_t x;
        x.ack = who;
        x.gnt = who;
        x.adr = adr;
        x.we  = we;
        x.dat = dat;
        return x;
    endfunction

    function automatic xact_t sample(input logic we, input logic [1:0] who);
        xact_t s;
        s.ack = {m1_ack_o, m0_ack_o};
        s.gnt = grant_o;
        s.adr = s_adr_o;
        s.we  = s_we_o;
        s.dat = we ? s_dat_o : ((who == 2'b10) ? m1_dat_o : m0_dat_o);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_m0();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    endtask

    task automatic clear_m1();
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    endtask

    task automatic test_reset();
        rstn_i = 0;
        clear_m0();
        clear_m1();
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_held: outputs %h, want 0", all_out);
        end
        rstn_i = 1;
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_release: outputs %h, want 0", all_out);
        end
        s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL idle_stray_ack: outputs %h, want 0", all_out);
        end
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic test_single();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
        #1;
        n_checks++;
        if (grant_o !== 2'b00) begin
            n_fail++; $display("FAIL single_latency: grant %b, want 00", grant_o);
        end
        tick();
        n_checks++;
        if ({grant_o, s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m1_ack_o}
            !== {2'b01, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_grant: grant %b cyc %b stb %b adr %h ack0 %b ack1 %b",
                     grant_o, s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m1_ack_o);
        end
        tick();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        exp_q.push_back(mk(2'b01, 32'h100, 1'b0, 32'hDEAD_BEEF));
        #1;
        exp_x = exp_q.pop_front();
        obs_x = sample(exp_x.we, exp_x.gnt);
        n_checks++;
        if (obs_x !== exp_x) begin
            n_fail++; $display("FAIL single_read: got %h want %h", obs_x, exp_x);
        end
        tick();
        s_ack_i = 0; s_dat_i = '0;
        clear_m0();
        #1;
        n_checks++;
        if ({grant_o, s_cyc_o} !== {2'b01, 1'b0}) begin
            n_fail++; $display("FAIL single_drop: grant %b cyc %b, want 01 0", grant_o, s_cyc_o);
        end
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL single_idle: outputs %h, want 0", all_out);
        end
    endtask

    task automatic test_contention();
        rstn_i = 0;
        tick();
        rstn_i = 1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20; m1_sel_i = 4'hF;
        tick();
        n_checks++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL contention_first: grant %b, want 01", grant_o);
        end
        s_ack_i = 1; s_dat_i = 32'h1111_1111;
        exp_q.push_back(mk(2'b01, 32'h10, 1'b0, 32'h1111_1111));
        #1;
        exp_x = exp_q.pop_front();
        obs_x = sample(exp_x.we, exp_x.gnt);
        n_checks++;
        if (obs_x !== exp_x) begin
            n_fail++; $display("FAIL contention_m0: got %h want %h", obs_x, exp_x);
        end
        tick();
        s_ack_i = 0;
        clear_m0();
        #1;
        n_checks++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL contention_hold: grant %b, want 01", grant_o);
        end
        tick();
        n_checks++;
        if ({grant_o, s_cyc_o, s_adr_o} !== {2'b10, 1'b1, 32'h20}) begin
            n_fail++;
            $display("FAIL contention_handover: grant %b cyc %b adr %h, want 10 1 20",
                     grant_o, s_cyc_o, s_adr_o);
        end
        s_ack_i = 1; s_dat_i = 32'h2222_2222;
        exp_q.push_back(mk(2'b10, 32'h20, 1'b0, 32'h2222_2222));
        #1;
        exp_x = exp_q.pop_front();
        obs_x = sample(exp_x.we, exp_x.gnt);
        n_checks++;
        if (obs_x !== exp_x) begin
            n_fail++; $display("FAIL contention_m1: got %h want %h", obs_x, exp_x);
        end
        tick();
        s_ack_i = 0; s_dat_i = '0;
        clear_m1();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL contention_idle: outputs %h, want 0", all_out);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    g;
        logic [AW-1:0] a;
        m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF;
        tick();
        for (int k = 0; k < 6; k++) begin
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            m0_adr_i = 32'h3000 + 32'(k * 4);
            m1_adr_i = 32'h4000 + 32'(k * 4);
            a = (g == 2'b01) ? m0_adr_i : m1_adr_i;
            s_ack_i = 1; s_dat_i = 32'hA000_0000 + 32'(k);
            exp_q.push_back(mk(g, a, 1'b0, s_dat_i));
            #1;
            n_checks++;
            if (grant_o !== g) begin
                n_fail++; $display("FAIL rr_grant_%0d: grant %b, want %b", k, grant_o, g);
            end
            exp_x = exp_q.pop_front();
            obs_x = sample(exp_x.we, exp_x.gnt);
            n_checks++;
            if (obs_x !== exp_x) begin
                n_fail++; $display("FAIL rr_xfer_%0d: got %h want %h", k, obs_x, exp_x);
            end
            tick();
            s_ack_i = 0;
            if (g == 2'b01) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else            begin m1_cyc_i = 0; m1_stb_i = 0; end
            tick();
            if (g == 2'b01) begin m0_cyc_i = 1; m0_stb_i = 1; end
            else            begin m1_cyc_i = 1; m1_stb_i = 1; end
        end
        clear_m0();
        clear_m1();
        s_ack_i = 0; s_dat_i = '0;
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL rr_idle: outputs %h, want 0", all_out);
        end
    endtask

    task automatic test_locked_burst();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF;
        m1_adr_i = 32'h2000; m1_dat_i = 32'hB000_0000;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h500; m0_sel_i = 4'hF;
        for (int b = 0; b < 4; b++) begin
            m1_adr_i = 32'h2000 + 32'(b * 4);
            m1_dat_i = 32'hB000_0000 + 32'(b);
            s_ack_i = 1; s_dat_i = 32'h0;
            exp_q.push_back(mk(2'b10, m1_adr_i, 1'b1, m1_dat_i));
            #1;
            n_checks++;
            if (grant_o !== 2'b10) begin
                n_fail++; $display("FAIL burst_lock_%0d: grant %b, want 10", b, grant_o);
            end
            exp_x = exp_q.pop_front();
            obs_x = sample(exp_x.we, exp_x.gnt);
            n_checks++;
            if (obs_x !== exp_x) begin
                n_fail++; $display("FAIL burst_beat_%0d: got %h want %h", b, obs_x, exp_x);
            end
            tick();
        end
        s_ack_i = 0;
        clear_m1();
        #1;
        n_checks++;
        if ({grant_o, m0_ack_o} !== {2'b10, 1'b0}) begin
            n_fail++; $display("FAIL burst_release: grant %b ack0 %b, want 10 0", grant_o, m0_ack_o);
        end
        tick();
        n_checks++;
        if ({grant_o, s_adr_o} !== {2'b01, 32'h500}) begin
            n_fail++; $display("FAIL burst_m0_after: grant %b adr %h, want 01 500", grant_o, s_adr_o);
        end
        s_ack_i = 1; s_dat_i = 32'hC0FF_EE00;
        exp_q.push_back(mk(2'b01, 32'h500, 1'b0, 32'hC0FF_EE00));
        #1;
        exp_x = exp_q.pop_front();
        obs_x = sample(exp_x.we, exp_x.gnt);
        n_checks++;
        if (obs_x !== exp_x) begin
            n_fail++; $display("FAIL burst_m0_read: got %h want %h", obs_x, exp_x);
        end
        tick();
        s_ack_i = 0; s_dat_i = '0;
        clear_m0();
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL burst_idle: outputs %h, want 0", all_out);
        end
    endtask

    task automatic test_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h600; m0_sel_i = 4'hF;
        tick();
        for (int j = 0; j < TO - 1; j++) begin
            n_checks++;
            if ({timeout_o, m0_err_o, s_stb_o} !== 3'b001) begin
                n_fail++;
                $display("FAIL wd_quiet_%0d: to/err/stb %b, want 001", j,
                         {timeout_o, m0_err_o, s_stb_o});
            end
            tick();
        end
        n_checks++;
        if ({timeout_o, m0_err_o, s_stb_o, m1_err_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL wd_fire: to/err0/stb/err1 %b, want 1100",
                     {timeout_o, m0_err_o, s_stb_o, m1_err_o});
        end
        tick();
        n_checks++;
        if ({timeout_o, m0_err_o, s_stb_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL wd_one_cycle: to/err/stb %b, want 001", {timeout_o, m0_err_o, s_stb_o});
        end
        clear_m0();
        tick();
        tick();

        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h604; m0_sel_i = 4'hF;
        tick();
        for (int j = 0; j < TO - 1; j++) tick();
        s_ack_i = 1; s_dat_i = 32'h5A5A_5A5A;
        exp_q.push_back(mk(2'b01, 32'h604, 1'b0, 32'h5A5A_5A5A));
        #1;
        n_checks++;
        if ({timeout_o, m0_err_o, s_stb_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL wd_ack_wins: to/err/stb %b, want 001", {timeout_o, m0_err_o, s_stb_o});
        end
        exp_x = exp_q.pop_front();
        obs_x = sample(exp_x.we, exp_x.gnt);
        n_checks++;
        if (obs_x !== exp_x) begin
            n_fail++; $display("FAIL wd_ack_data: got %h want %h", obs_x, exp_x);
        end
        tick();
        s_ack_i = 0; s_dat_i = '0;
        clear_m0();
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL wd_idle: outputs %h, want 0", all_out);
        end
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h700;
        m1_dat_i = 32'h1234; m1_sel_i = 4'hF;
        tick();
        n_checks++;
        if (grant_o !== 2'b10) begin
            n_fail++; $display("FAIL rmid_grant: grant %b, want 10", grant_o);
        end
        rstn_i = 0;
        tick();
        s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL rmid_drop: outputs %h, want 0", all_out);
        end
        rstn_i = 1;
        s_ack_i = 0; s_dat_i = '0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h800; m0_sel_i = 4'hF;
        tick();
        n_checks++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL rmid_m0_first: grant %b, want 01", grant_o);
        end
        clear_m0();
        clear_m1();
        tick();
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL rmid_idle: outputs %h, want 0", all_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, want done");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_locked_burst();
        test_watchdog();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
